// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream program loader that fills instruction memory
// Packs hi/lo byte pairs into words, writes them, and optionally reads each word back to check it.
module instr_mem_loader #(
  parameter int ADDR_W = 16,
  parameter int VERIFY = 1,
  parameter int ERR_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [1:0]        Control,
  output logic [ADDR_W-1:0] InstrAddr,
  output logic [15:0]       InstrIn,
  input  logic [15:0]       InstrOut,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ERR_W-1:0]  err_count
);

  typedef enum logic [2:0] {IDLE, RX_HI, RX_LO, WRITE, VREAD, VCHECK, DONE} state_t;

  state_t            state, stateNext;
  logic [ADDR_W-1:0] addr, addrNext;
  logic [15:0]       remaining, remainingNext;
  logic [7:0]        hiByte, hiNext, loByte, loNext;
  logic              errorNext;
  logic [ERR_W-1:0]  errCountNext;
  logic              doAdvance;
  logic              accept;

  assign accept = byte_valid && byte_ready;

  always_comb begin
    stateNext     = state;
    addrNext      = addr;
    remainingNext = remaining;
    hiNext        = hiByte;
    loNext        = loByte;
    errorNext     = error;
    errCountNext  = err_count;
    doAdvance     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          addrNext      = base_addr;
          remainingNext = word_count;
          errorNext     = 1'b0;
          errCountNext  = '0;
          stateNext     = (word_count == 16'd0) ? DONE : RX_HI;
        end
      end
      RX_HI: begin
        if (accept) begin
          hiNext    = byte_in;
          stateNext = RX_LO;
        end
      end
      RX_LO: begin
        if (accept) begin
          loNext    = byte_in;
          stateNext = WRITE;
        end
      end
      WRITE: begin
        if (VERIFY != 0) stateNext = VREAD;
        else             doAdvance = 1'b1;
      end
      VREAD:  stateNext = VCHECK;
      VCHECK: begin
        // Read data arrives the cycle after the VREAD command.
        if (InstrOut != {hiByte, loByte}) begin
          errorNext = 1'b1;
          if (err_count != {ERR_W{1'b1}}) errCountNext = err_count + ERR_W'(1);
        end
        doAdvance = 1'b1;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (doAdvance) begin
      if (remaining == 16'd1) begin
        stateNext = DONE;
      end else begin
        remainingNext = remaining - 16'd1;
        addrNext      = addr + ADDR_W'(1);
        stateNext     = RX_HI;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      hiByte     <= '0;
      loByte     <= '0;
      byte_ready <= 1'b0;
      Control    <= 2'b00;
      InstrAddr  <= '0;
      InstrIn    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= stateNext;
      addr       <= addrNext;
      remaining  <= remainingNext;
      hiByte     <= hiNext;
      loByte     <= loNext;
      error      <= errorNext;
      err_count  <= errCountNext;
      byte_ready <= (stateNext == RX_HI) || (stateNext == RX_LO);
      busy       <= (stateNext != IDLE);
      done       <= (stateNext == DONE);
      Control    <= (stateNext == WRITE) ? 2'b10 :
                    (stateNext == VREAD) ? 2'b01 : 2'b00;
      if (stateNext == WRITE || stateNext == VREAD) InstrAddr <= addrNext;
      if (stateNext == WRITE) InstrIn <= {hiNext, loNext};
    end
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side counterpart of the fetch path. The fetch cycle only reads instruction memory (PC → InstrAddr, Control=01 → InstrOut → MIDR/IR). This block fills instruction memory before the processor runs.
- It receives a program as a byte stream over a valid/ready handshake and packs byte pairs into 16-bit instruction words.
- Each word is written into instruction memory on one port (Control/InstrAddr/InstrIn). With VERIFY=1, each word is read back and checked.
- `busy` holds the fetch sequencer off while loading is in progress.

Parameters:
- ADDR_W, 16, instruction address width.
- VERIFY, 1, 1 = read back and compare every written word; 0 = write only.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle load request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; latched on accepted start.
- word_count  in  16  number of words to load; latched on accepted start.
- byte_in  in  8  program byte; the high byte of each word is sent first.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts byte_in this cycle.
- Control  out  2  memory command: 00 idle, 01 read, 10 write; 11 is never driven.
- InstrAddr  out  ADDR_W  memory address.
- InstrIn  out  16  memory write data.
- InstrOut  in  16  memory read data; valid one cycle after Control=01.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at the end of a load.
- error  out  1  sticky flag: at least one verify mismatch.
- err_count  out  ERR_W  number of mismatches, saturating.

Behaviour:
- Reset state: all outputs 0, state IDLE.
  - Reset asserted mid-load returns the block to IDLE immediately and discards any partial word.
  - Words already written stay in memory.
  - No further memory command is issued after reset asserts.
- States: IDLE, RX_HI, RX_LO, WRITE, VREAD, VCHECK, DONE.
- IDLE: byte_ready=0, Control=00. On start=1:
  - latch addr←base_addr and remaining←word_count;
  - clear error and err_count;
  - go to DONE if word_count==0, otherwise go to RX_HI.
- start outside IDLE is ignored.
- RX_HI: byte_ready=1. On byte_valid&&byte_ready, hi←byte_in and go to RX_LO. Otherwise hold.
- RX_LO: byte_ready=1. On a handshake, lo←byte_in and go to WRITE.
- Control=00 in RX_HI and RX_LO. A stalled stream (byte_valid low) produces no memory activity.
- WRITE (exactly one cycle):
  - Control=10, InstrAddr=addr, InstrIn={hi,lo}, byte_ready=0.
  - Next state: VREAD if VERIFY=1, otherwise the ADVANCE step.
- VREAD (one cycle): Control=01, InstrAddr=addr.
- VCHECK (one cycle):
  - Control=00; compare InstrOut with {hi,lo}.
  - On mismatch: error←1 and err_count←err_count+1, saturating at all ones.
  - Then perform the ADVANCE step.
- ADVANCE (not a state; it chooses the next state):
  - If remaining==1, go to DONE.
  - Otherwise remaining←remaining−1 and addr←addr+1, then go to RX_HI.
  - addr wraps modulo 2^ADDR_W, so 0xFFFF+1=0x0000.
- DONE: done=1 for one cycle, then IDLE.
- busy: 1 in every state except IDLE; it falls in the cycle after DONE.
- error and err_count hold their values after DONE until the next accepted start.
- Outputs are registered. InstrAddr and InstrIn hold their last values when Control=00.
- Throughput with back-to-back bytes: 3 cycles/word with VERIFY=0, 5 cycles/word with VERIFY=1.
- word_count=0xFFFF with wrap is legal; the loader does not detect address overlap.

Test Plan:
1. Reset: assert reset_n=0 mid-clock → all outputs 0 asynchronously. Release → IDLE, busy=0.
2. Basic load (VERIFY=1, ideal memory model): base_addr=0x0010, word_count=2, bytes 0x12,0x34,0xAB,0xCD back-to-back → write 0x1234 at 0x0010, then write 0xABCD at 0x0011. Expect:
   - each write is followed by a Control=01 read of the same address;
   - done pulses 11 cycles after start;
   - error=0, err_count=0.
3. word_count=0 → cycle 1 in DONE with done=1, cycle 2 in IDLE. Control stays 00 throughout, byte_ready never rises.
4. Stall: byte_valid deasserted for 4 cycles between the high and low byte → loader stays in RX_LO with byte_ready=1 and Control=00. The word is written correctly afterwards.
5. Verify failure: the memory model returns 0xABCC when 0x0011 is read → error=1 and err_count=1 after the load. A new start clears both.
6. Wrap and reset: base_addr=0xFFFF, word_count=2 → second write goes to 0x0000. Separately, assert reset_n in RX_LO → no write is issued and the block returns to IDLE.
